// File: rtl/tag_stream_generator.sv
// tag_stream_generator
// Folds a valid/ready stream of DATA_SIZE-bit beats into one TAG_SIZE-bit
// keyed integrity tag per in_last-delimited message. Each beat is split into
// TAG_SIZE-bit blocks. Every block gets its own flip and rotate-left setting
// from the key register. The transformed blocks are XORed into one value per
// beat, and that value is folded into a rotating accumulator.
// Optional build macro: TAG_VERIFY_EN adds the exp_tag/out_match compare.
// The tag path is the same whether or not the macro is defined.

module tag_stream_generator #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TAG_SIZE  = 8,
    localparam int unsigned NB    = DATA_SIZE / TAG_SIZE,
    localparam int unsigned SW    = $clog2(TAG_SIZE),
    localparam int unsigned FW    = 1 + SW,
    localparam int unsigned KEY_W = NB * FW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_load,
    input  logic [KEY_W-1:0]     key_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAG_SIZE-1:0]  out_tag,
    output logic [15:0]          out_beats,
`ifdef TAG_VERIFY_EN
    input  logic [TAG_SIZE-1:0]  exp_tag,
    output logic                 out_match,
`endif
    output logic                 busy
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [KEY_W-1:0]     key_q, key_d;
    logic [TAG_SIZE-1:0]  acc_q, acc_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [TAG_SIZE-1:0]  tag_q, tag_d;
    logic [15:0]          beats_q, beats_d;
`ifdef TAG_VERIFY_EN
    logic                 match_q, match_d;
`endif

    logic [TAG_SIZE-1:0]  beat_v;
    logic [TAG_SIZE-1:0]  acc_next;
    logic [15:0]          cnt_inc;
    logic                 busy_int;
    logic                 key_accept;
    logic                 ready_int;
    logic                 beat_fire;

    // One block: optional bit flip, then rotate left by the key amount.
    // The rotate duplicates the block and keeps the upper half of the shifted
    // result, so an amount of zero returns the flipped block as it is.
    function automatic logic [TAG_SIZE-1:0] xform_blk(
        input logic [TAG_SIZE-1:0] blk,
        input logic [FW-1:0]       fld
    );
        logic [TAG_SIZE-1:0]   flipped;
        logic [2*TAG_SIZE-1:0] dbl;
        flipped = fld[0] ? ~blk : blk;
        dbl     = {flipped, flipped} << fld[FW-1:1];
        return dbl[2*TAG_SIZE-1 -: TAG_SIZE];
    endfunction

    // Beat value: XOR of all transformed blocks of the offered beat.
    always_comb begin
        beat_v = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            beat_v = beat_v ^ xform_blk(in_data[i*TAG_SIZE +: TAG_SIZE],
                                        key_q[i*FW +: FW]);
        end
    end

    // Handshake qualifiers, the accumulator fold and the saturating beat count.
    always_comb begin
        busy_int   = (cnt_q != 16'd0) || (state_q == HOLD);
        key_accept = key_load && !busy_int;
        ready_int  = (state_q == ACCUM) && !key_accept;
        beat_fire  = in_valid && ready_int;
        acc_next   = {acc_q[TAG_SIZE-2:0], acc_q[TAG_SIZE-1]} ^ beat_v;
        cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end

    // Next-state logic: key load, beat accumulation, tag capture and hand-off.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        beats_d = beats_q;
`ifdef TAG_VERIFY_EN
        match_d = match_q;
`endif
        if (key_accept) begin
            key_d = key_in;
        end
        case (state_q)
            ACCUM: begin
                if (beat_fire) begin
                    if (in_last) begin
                        tag_d   = acc_next;
                        beats_d = cnt_inc;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = HOLD;
`ifdef TAG_VERIFY_EN
                        match_d = (acc_next == exp_tag);
`endif
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_inc;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State registers with synchronous reset; a reset mid-message drops the partial message.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            key_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
            beats_q <= '0;
`ifdef TAG_VERIFY_EN
            match_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            beats_q <= beats_d;
`ifdef TAG_VERIFY_EN
            match_q <= match_d;
`endif
        end
    end

    // Outputs. in_ready and busy are forced low while reset is asserted.
    always_comb begin
        in_ready  = ready_int && !reset;
        busy      = busy_int && !reset;
        out_valid = (state_q == HOLD);
        out_tag   = tag_q;
        out_beats = beats_q;
`ifdef TAG_VERIFY_EN
        out_match = match_q;
`endif
    end

endmodule

// File: tb/tb_tag_stream_generator.sv
// Testbench for tag_stream_generator at the default sizes (32-bit beats, 8-bit tags).
// The stimulus pushes the expected tag for each message into a queue.
// A separate monitor pops an entry and compares it on every output handshake.
module tb_tag_stream_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_load;
    logic [15:0] key_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_tag;
    logic [15:0] out_beats;
    logic        busy;
`ifdef TAG_VERIFY_EN
    logic [7:0]  exp_tag;
    logic        out_match;
`endif

    typedef struct {
        logic [7:0]  tag;
        logic [15:0] beats;
        logic        match;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tag_stream_generator #(
        .DATA_SIZE(32),
        .TAG_SIZE (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_load (key_load),
        .key_in   (key_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_tag  (out_tag),
        .out_beats(out_beats),
`ifdef TAG_VERIFY_EN
        .exp_tag  (exp_tag),
        .out_match(out_match),
`endif
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_tag(input logic [7:0] t, input logic [15:0] b, input logic m);
        exp_t e;
        e.tag   = t;
        e.beats = b;
        e.match = m;
        sb_q.push_back(e);
    endtask

    // Call at posedge+1; returns at posedge+1 after the edge that accepted the beat.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int unsigned n;
        logic        taken;
        n        = 0;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!taken && n < 20) begin
            #1;
            taken = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!taken) begin
            chk("beat_accept_timeout", 32'(taken), 32'd1);
        end
    endtask

    task automatic load_key(input logic [15:0] k, input logic ready_req);
        key_load = 1'b1;
        key_in   = k;
        #1;
        chk("key_cycle_in_ready", 32'(in_ready), 32'(ready_req));
        @(posedge clk);
        #1;
        key_load = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            chk("idle_timeout", 32'(busy), 32'd0);
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_tag", 32'(out_tag), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_tag", 32'(out_tag), 32'(e.tag));
                    chk("out_beats", 32'(out_beats), 32'(e.beats));
`ifdef TAG_VERIFY_EN
                    chk("out_match", 32'(out_match), 32'(e.match));
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n;
        reset     = 1'b1;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
`ifdef TAG_VERIFY_EN
        exp_tag   = 8'h44;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_beats", 32'(out_beats), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Test 1: key 0, single-beat message; out_valid rises the next cycle.
        expect_tag(8'h44, 16'd1, 1'b1);
        send_beat(32'h11223344, 1'b1);
        chk("t1_latency_valid", 32'(out_valid), 32'd1);

        // Test 2: block 0 flip, then block 0 rotate-left by 1.
        wait_idle();
        load_key(16'h0001, 1'b0);
        expect_tag(8'hBB, 16'd1, 1'b0);
        send_beat(32'h11223344, 1'b1);
        wait_idle();
        load_key(16'h0002, 1'b0);
        expect_tag(8'h88, 16'd1, 1'b0);
        send_beat(32'h11223344, 1'b1);
        wait_idle();
        load_key(16'h0000, 1'b0);

        // Test 3: two-beat message.
        expect_tag(8'h89, 16'd2, 1'b0);
        send_beat(32'h11223344, 1'b0);
        chk("t3_busy_mid", 32'(busy), 32'd1);
        send_beat(32'h00000001, 1'b1);
        wait_idle();

        // Test 4: a key load mid-message is ignored; the tag stays held under backpressure.
        out_ready = 1'b0;
        expect_tag(8'h89, 16'd2, 1'b0);
        send_beat(32'h11223344, 1'b0);
        load_key(16'h0001, 1'b1);
        send_beat(32'h00000001, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_tag", 32'(out_tag), 32'h89);
            chk("t4_hold_beats", 32'(out_beats), 32'd2);
            chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        // Key must still be 0 after the ignored load.
        expect_tag(8'h44, 16'd1, 1'b1);
        send_beat(32'h11223344, 1'b1);
        wait_idle();

        // Test 5: reset after the first beat of a two-beat message drops the message.
        send_beat(32'h11223344, 1'b0);
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("t5_post_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        expect_tag(8'h44, 16'd1, 1'b1);
        send_beat(32'h11223344, 1'b1);
        wait_idle();

`ifdef TAG_VERIFY_EN
        // Test 6: out_match for a correct and for a wrong expected tag.
        exp_tag = 8'h44;
        expect_tag(8'h44, 16'd1, 1'b1);
        send_beat(32'h11223344, 1'b1);
        wait_idle();
        exp_tag = 8'h45;
        expect_tag(8'h44, 16'd1, 1'b0);
        send_beat(32'h11223344, 1'b1);
        wait_idle();
`endif

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
